// File: rtl/ps2_scan_ctrl.sv
// ps2_scan_ctrl: PS/2 keyboard receiver with frame checking,
// E0/F0 prefix folding and a valid/ready event holder.
module ps2_scan_ctrl #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kbclk,
  input  logic       kbdata,
  output logic [7:0] code,
  output logic       code_break,
  output logic       code_ext,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       frame_err,
  output logic       overflow,
  output logic       busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    CHECK = 2'b10
  } fstate_t;

  typedef enum logic [1:0] {
    BASE    = 2'b00,
    EXT     = 2'b01,
    BRK     = 2'b10,
    EXT_BRK = 2'b11
  } pstate_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_s;
  logic                   clk_d;
  logic                   dat_s;
  logic                   fall;

  fstate_t       f_state, f_next;
  pstate_t       p_state, p_next;
  logic [3:0]    bitcnt, bit_next;
  logic [TW-1:0] tmo, tmo_next, tmo_inc;
  logic [9:0]    sr, sr_next;
  logic [7:0]    rx_byte;
  logic          good;
  logic          is_e0;
  logic          is_f0;
  logic          p_ext;
  logic          p_brk;
  logic          err_set;
  logic          emit;

  assign clk_s   = clk_sync[SYNC_STAGES-1];
  assign dat_s   = dat_sync[SYNC_STAGES-1];
  assign fall    = clk_d & ~clk_s;
  assign tmo_inc = tmo + TW'(1);
  assign rx_byte = sr[7:0];
  assign good    = (^sr[8:0]) & sr[9];
  assign is_e0   = (rx_byte == 8'hE0);
  assign is_f0   = (rx_byte == 8'hF0);
  assign p_ext   = p_state[0];
  assign p_brk   = p_state[1];
  assign busy    = (f_state != IDLE);

  // idle PS/2 lines are high, so the chain presets to 1
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_d    <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], kbclk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], kbdata};
      clk_d    <= clk_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_state <= IDLE;
      p_state <= BASE;
      bitcnt  <= '0;
      tmo     <= '0;
      sr      <= '0;
    end else begin
      f_state <= f_next;
      p_state <= p_next;
      bitcnt  <= bit_next;
      tmo     <= tmo_next;
      sr      <= sr_next;
    end
  end

  always_comb begin
    f_next   = f_state;
    p_next   = p_state;
    bit_next = bitcnt;
    tmo_next = tmo;
    sr_next  = sr;
    err_set  = 1'b0;
    emit     = 1'b0;
    unique case (f_state)
      IDLE: begin
        if (fall && !dat_s) begin
          f_next   = SHIFT;
          bit_next = '0;
          tmo_next = '0;
        end
      end
      SHIFT: begin
        if (fall) begin
          sr_next  = {dat_s, sr[9:1]};
          bit_next = bitcnt + 4'd1;
          tmo_next = '0;
          if (bitcnt == 4'd9) f_next = CHECK;
        end else if (tmo_inc == TMO_LAST) begin
          // error is registered, so it lands as tmo reaches the limit
          f_next  = IDLE;
          err_set = 1'b1;
          p_next  = BASE;
        end else begin
          tmo_next = tmo_inc;
        end
      end
      CHECK: begin
        f_next = IDLE;
        if (!good) begin
          err_set = 1'b1;
          p_next  = BASE;
        end else begin
          unique case (1'b1)
            is_e0:   p_next = pstate_t'({p_brk, 1'b1});
            is_f0:   p_next = pstate_t'({1'b1, p_ext});
            default: begin
              emit   = 1'b1;
              p_next = BASE;
            end
          endcase
        end
      end
      default: f_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code       <= '0;
      code_break <= 1'b0;
      code_ext   <= 1'b0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_err <= err_set;
      overflow  <= 1'b0;
      if (emit) begin
        if (!code_valid || code_ready) begin
          code       <= rx_byte;
          code_break <= p_brk;
          code_ext   <= p_ext;
          code_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (code_valid && code_ready) begin
        code_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// tb_ps2_scan_ctrl: scenario tasks plus randomized frame
// streams checked against a prefix-folding reference model.
module tb_ps2_scan_ctrl;
  localparam int TMO = 64;
  localparam int H   = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       kbclk;
  logic       kbdata;
  logic [7:0] code;
  logic       code_break;
  logic       code_ext;
  logic       code_valid;
  logic       code_ready;
  logic       frame_err;
  logic       overflow;
  logic       busy;

  ps2_scan_ctrl #(
    .TIMEOUT_CYCLES(TMO),
    .SYNC_STAGES   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .kbclk     (kbclk),
    .kbdata    (kbdata),
    .code      (code),
    .code_break(code_break),
    .code_ext  (code_ext),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .frame_err (frame_err),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] c;
    logic       b;
    logic       e;
  } ev_t;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   vrise  = -1;
  logic vprev  = 1'b0;
  ev_t  evq[$];
  int   errq[$];
  logic errbusy[$];
  int   ovfq[$];

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      vprev = 1'b0;
    end else begin
      if (frame_err) begin
        errq.push_back(cyc);
        errbusy.push_back(busy);
      end
      if (overflow) ovfq.push_back(cyc);
      if (code_valid && !vprev) vrise = cyc;
      if (code_valid && code_ready)
        evq.push_back('{c: code, b: code_break, e: code_ext});
      vprev = code_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b,
                                           input logic bad_par,
                                           input logic bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] fr, input int nbits,
                           output int last);
    last = 0;
    for (int i = 0; i < nbits; i++) begin
      kbdata = fr[i];
      tick(H);
      kbclk = 1'b0;
      last  = cyc;
      tick(H);
      kbclk = 1'b1;
    end
    kbdata = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic bad_par,
                      input logic bad_stop, output int last);
    send_bits(mk_frame(b, bad_par, bad_stop), 11, last);
    tick(H);
  endtask

  task automatic clear_q();
    evq.delete();
    errq.delete();
    errbusy.delete();
    ovfq.delete();
    vrise = -1;
  endtask

  task automatic chk_ev(input string nm, input int idx,
                        input logic [7:0] c, input logic b, input logic e);
    n_chk++;
    if (idx >= evq.size()) begin
      n_fail++;
      $display("FAIL %s: event %0d missing, have %0d", nm, idx, evq.size());
    end else if (evq[idx].c !== c || evq[idx].b !== b || evq[idx].e !== e) begin
      n_fail++;
      $display("FAIL %s: got code=%h brk=%b ext=%b, want code=%h brk=%b ext=%b",
               nm, evq[idx].c, evq[idx].b, evq[idx].e, c, b, e);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    kbclk      = 1'b1;
    kbdata     = 1'b1;
    code_ready = 1'b1;
    tick(4);
    chk_int("reset code", int'(code), 0);
    chk_int("reset flags", int'({code_break, code_ext}), 0);
    chk_int("reset valid", int'(code_valid), 0);
    chk_int("reset err_ovf", int'({frame_err, overflow}), 0);
    chk_int("reset busy", int'(busy), 0);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_single();
    int last;
    clear_q();
    send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 5, last);
    chk_int("busy mid frame", int'(busy), 1);
    send_bits(mk_frame(8'h1C, 1'b0, 1'b0) >> 5, 6, last);
    tick(H);
    chk_int("single count", evq.size(), 1);
    chk_ev("single 1C", 0, 8'h1C, 1'b0, 1'b0);
    chk_int("single latency", vrise, last + 4);
    chk_int("single no err", errq.size(), 0);
    chk_int("single idle busy", int'(busy), 0);
  endtask

  task automatic test_break();
    int last;
    clear_q();
    send(8'hF0, 1'b0, 1'b0, last);
    chk_int("no event after F0", evq.size(), 0);
    send(8'h1C, 1'b0, 1'b0, last);
    chk_int("break count", evq.size(), 1);
    chk_ev("break 1C", 0, 8'h1C, 1'b1, 1'b0);
  endtask

  task automatic test_ext_brk();
    int last;
    clear_q();
    send(8'hE0, 1'b0, 1'b0, last);
    send(8'hF0, 1'b0, 1'b0, last);
    send(8'h75, 1'b0, 1'b0, last);
    send(8'h75, 1'b0, 1'b0, last);
    chk_int("ext_brk count", evq.size(), 2);
    chk_ev("ext_brk 75", 0, 8'h75, 1'b1, 1'b1);
    chk_ev("plain 75", 1, 8'h75, 1'b0, 1'b0);
  endtask

  task automatic test_bad_frame();
    int last;
    clear_q();
    send(8'h1C, 1'b1, 1'b0, last);
    chk_int("parity err count", errq.size(), 1);
    if (errq.size() > 0) chk_int("parity err time", errq[0], last + 4);
    chk_int("parity no event", evq.size(), 0);
    send(8'hF0, 1'b0, 1'b0, last);
    send(8'h42, 1'b0, 1'b1, last);
    send(8'h1C, 1'b0, 1'b0, last);
    chk_int("stop err count", errq.size(), 2);
    chk_int("bad clears count", evq.size(), 1);
    chk_ev("bad clears brk", 0, 8'h1C, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    int last;
    clear_q();
    send(8'hF0, 1'b0, 1'b0, last);
    send_bits(mk_frame(8'h29, 1'b0, 1'b0), 5, last);
    tick(TMO + 10);
    chk_int("timeout err count", errq.size(), 1);
    if (errq.size() > 0) begin
      chk_int("timeout err time", errq[0], last + 2 + TMO);
      chk_int("timeout busy", int'(errbusy[0]), 0);
    end
    send(8'h29, 1'b0, 1'b0, last);
    chk_int("after timeout count", evq.size(), 1);
    chk_ev("after timeout 29", 0, 8'h29, 1'b0, 1'b0);
    clear_q();
    send_bits(mk_frame(8'h29, 1'b0, 1'b0), 5, last);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(TMO + 10);
    chk_int("rst mid frame no err", errq.size(), 0);
    chk_int("rst mid frame busy", int'(busy), 0);
    send(8'h1C, 1'b0, 1'b0, last);
    chk_ev("after rst 1C", 0, 8'h1C, 1'b0, 1'b0);
    chk_int("after rst count", evq.size(), 1);
  endtask

  task automatic test_overflow();
    int last;
    clear_q();
    code_ready = 1'b0;
    send(8'h1C, 1'b0, 1'b0, last);
    send(8'h32, 1'b0, 1'b0, last);
    chk_int("ovf count", ovfq.size(), 1);
    if (ovfq.size() > 0) chk_int("ovf time", ovfq[0], last + 4);
    chk_int("ovf held valid", int'(code_valid), 1);
    chk_int("ovf held code", int'(code), 'h1C);
    chk_int("ovf no xfer", evq.size(), 0);
    code_ready = 1'b1;
    tick(1);
    chk_int("xfer drops valid", int'(code_valid), 0);
    tick(3);
    chk_int("one xfer", evq.size(), 1);
    chk_ev("xfer 1C", 0, 8'h1C, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int   last;
    int   n_err;
    logic m_ext;
    logic m_brk;
    ev_t  exp_q[$];
    clear_q();
    n_err = 0;
    m_ext = 1'b0;
    m_brk = 1'b0;
    for (int f = 0; f < 40; f++) begin
      int          k;
      logic [7:0]  b;
      logic        bp;
      logic        bs;
      k  = int'($urandom_range(0, 9));
      bp = 1'b0;
      bs = 1'b0;
      b  = 8'($urandom_range(0, 255));
      if (k < 2) b = 8'hE0;
      else if (k < 4) b = 8'hF0;
      else if (b == 8'hE0 || b == 8'hF0) b = 8'h5A;
      if (k == 9) begin
        bp = 1'($urandom_range(0, 1));
        bs = ~bp;
      end
      if (bp || bs) begin
        n_err++;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end else if (b == 8'hE0) begin
        m_ext = 1'b1;
      end else if (b == 8'hF0) begin
        m_brk = 1'b1;
      end else begin
        exp_q.push_back('{c: b, b: m_brk, e: m_ext});
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
      send(b, bp, bs, last);
      tick(int'($urandom_range(0, 15)));
    end
    send(8'h11, 1'b0, 1'b0, last);
    exp_q.push_back('{c: 8'h11, b: m_brk, e: m_ext});
    chk_int("random event count", evq.size(), exp_q.size());
    chk_int("random err count", errq.size(), n_err);
    foreach (exp_q[i])
      chk_ev("random event", i, exp_q[i].c, exp_q[i].b, exp_q[i].e);
  endtask

  initial begin
    test_reset();
    test_single();
    test_break();
    test_ext_brk();
    test_bad_frame();
    test_timeout();
    test_overflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
